// File: rtl/oled_framebuffer_if.sv
// Byte-stream write port of the OLED framebuffer.
// master drives bytes; slave returns wr_ready.
interface oled_framebuffer_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_sof;
    logic       wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        output wr_sof,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  wr_sof,
        output wr_ready
    );
endinterface

// File: rtl/oled_framebuffer.sv
// Packs a byte stream into 32-bit row words and serves rows to the OLED scanner.
// OLED_FRAMEBUFFER_DOUBLE_BUFFER_EN selects two banks with a tear-free swap.
module oled_framebuffer #(
    parameter int ROWS     = 80,
    parameter int ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    oled_framebuffer_if.slave   wr,
    input  logic [ROW_BITS-1:0] row,
    output logic [31:0]         pixels,
    output logic                frame_done
);

`ifdef OLED_FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int DEPTH = 2 * ROWS;
`else
    localparam int DEPTH = ROWS;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam logic [ROW_BITS-1:0] LAST = ROW_BITS'(ROWS - 1);

    logic [31:0]         mem [DEPTH];
    logic [ROW_BITS-1:0] wr_row;
    logic [1:0]          wr_byte;
    logic [23:0]         word_q;
    logic                accept;
    logic                word_we;
    logic                frame_end;
    logic [31:0]         word;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;

    assign accept    = wr.wr_valid && wr.wr_ready;
    assign word_we   = accept && !wr.wr_sof && (wr_byte == 2'd3);
    assign frame_end = word_we && (wr_row == LAST);
    assign word      = {wr.wr_data, word_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_row  <= '0;
            wr_byte <= '0;
            word_q  <= '0;
        end else if (wr.wr_sof) begin
            wr_row  <= '0;
            wr_byte <= accept ? 2'd1 : 2'd0;
            word_q  <= accept ? {16'h0, wr.wr_data} : 24'h0;
        end else if (accept) begin
            wr_byte <= wr_byte + 2'd1;
            case (wr_byte)
                2'd0:    word_q[7:0]   <= wr.wr_data;
                2'd1:    word_q[15:8]  <= wr.wr_data;
                2'd2:    word_q[23:16] <= wr.wr_data;
                default: ;
            endcase
            if (word_we)
                wr_row <= (wr_row == LAST) ? '0 : wr_row + ROW_BITS'(1);
        end
    end

`ifdef OLED_FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam logic [AW-1:0] OFS = AW'(ROWS);

    logic                front;
    logic                swap_pending;
    logic                ready_q;
    logic [ROW_BITS-1:0] row_q;
    logic                swap;

    // Swap only at the scan wrap so a displayed frame is never torn.
    assign swap       = swap_pending && (row_q == LAST) && (row == '0);
    assign frame_done = swap && !reset;
    assign wr.wr_ready = ready_q;

    // Banks are stacked: bank 1 starts at word ROWS.
    assign wr_addr = AW'(wr_row) + (front ? '0 : OFS);
    assign rd_addr = AW'(row) + (front ? OFS : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            ready_q      <= 1'b1;
            row_q        <= '0;
        end else begin
            row_q <= row;
            if (frame_end) begin
                swap_pending <= 1'b1;
                ready_q      <= 1'b0;
            end
            if (swap) begin
                front        <= ~front;
                swap_pending <= 1'b0;
                ready_q      <= 1'b1;
            end
        end
    end
`else
    assign wr.wr_ready = 1'b1;
    assign wr_addr     = AW'(wr_row);
    assign rd_addr     = AW'(row);

    always_ff @(posedge clk) begin
        if (reset)
            frame_done <= 1'b0;
        else
            frame_done <= frame_end;
    end
`endif

    always_ff @(posedge clk) begin
        if (word_we)
            mem[wr_addr] <= word;
    end

    // Read-before-write: a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (reset)
            pixels <= '0;
        else if (int'(row) < ROWS)
            pixels <= mem[rd_addr];
        else
            pixels <= '0;
    end

endmodule
